// File: rtl/mdu_pkg.sv
// Shared op encodings and default latencies for the execute-stage multiply/divide unit.
// The MADD/MADDU codes are meaningful only when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning the HI/LO pair; results commit after a fixed latency.
// Optional macro MDU_MADD_EN adds MADD/MADDU (accumulate into HI/LO).
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HILOout,
  output logic        busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, quo_s, rem_s, quo_u, rem_u;
  logic        b_zero;

  // Products are formed at full 64-bit width so both halves are exact.
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Substitute a divisor of 1 on zero so the dividers never produce X; the result is discarded.
  assign b_zero = (B == 32'd0);
  assign div_b  = b_zero ? 32'd1 : B;
  assign quo_s  = $signed(A) / $signed(div_b);
  assign rem_s  = $signed(A) % $signed(div_b);
  assign quo_u  = A / div_b;
  assign rem_u  = A % div_b;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;

    if (busy_q) begin
      // In-flight ops belong to an older instruction, so Req does not stop them.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        hi_d   = temp_hi_q;
        lo_d   = temp_lo_q;
        busy_d = 1'b0;
      end
    end else if (!Req) begin
      case (op)
        OP_MULT: if (start) begin
          {temp_hi_d, temp_lo_d} = prod_s;
          cnt_d  = CW'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        OP_MULTU: if (start) begin
          {temp_hi_d, temp_lo_d} = prod_u;
          cnt_d  = CW'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        OP_DIV: if (start) begin
          // A zero divisor commits the current HI/LO back, leaving them unchanged.
          temp_hi_d = b_zero ? hi_q : rem_s;
          temp_lo_d = b_zero ? lo_q : quo_s;
          cnt_d     = CW'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
        OP_DIVU: if (start) begin
          temp_hi_d = b_zero ? hi_q : rem_u;
          temp_lo_d = b_zero ? lo_q : quo_u;
          cnt_d     = CW'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
`ifdef MDU_MADD_EN
        OP_MADD: if (start) begin
          {temp_hi_d, temp_lo_d} = {hi_q, lo_q} + prod_s;
          cnt_d  = CW'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        OP_MADDU: if (start) begin
          {temp_hi_d, temp_lo_d} = {hi_q, lo_q} + prod_u;
          cnt_d  = CW'(MULT_CYCLES);
          busy_d = 1'b1;
        end
`endif
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    HILOout = 32'd0;
    if (op == OP_MFHI)      HILOout = hi_q;
    else if (op == OP_MFLO) HILOout = lo_q;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: a vector table of mult/div ops plus hand sequences
// for squash, reset-abort, busy overlap and (with MDU_MADD_EN) accumulate.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, Req, start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic [31:0] HILOout;
  logic        busy;

  int errors = 0;
  int checks = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .Req(Req), .start(start), .op(op),
    .A(A), .B(B), .HILOout(HILOout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    op_e         vop;
    logic [31:0] a, b, pre_hi, pre_lo;
    int          cycles;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    start = 1'b0; op = OP_NONE; Req = 1'b0; A = '0; B = '0;
  endtask

  task automatic mt(input op_e o, input logic [31:0] v);
    op = o; A = v; start = 1'b0;
    tick();
    idle();
  endtask

  function automatic logic [31:0] rd(input op_e o);
    op = o;
    return 32'd0;
  endfunction

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    op = OP_MFHI; #1; h = HILOout;
    op = OP_MFLO; #1; l = HILOout;
    op = OP_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  logic [31:0] h, l;
  int          n;

  initial begin
    vecs[0] = '{"mult_neg",     OP_MULT,  32'd3,        32'hFFFFFFFE, 32'h0,  32'h0,  5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{"multu_carry",  OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,  5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{"multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  5,  32'hFFFFFFFE, 32'h00000001};
    vecs[3] = '{"mult_minsq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,  5,  32'h40000000, 32'h00000000};
    vecs[4] = '{"divu_7_2",     OP_DIVU,  32'd7,        32'd2,        32'h0,  32'h0,  10, 32'h00000001, 32'h00000003};
    vecs[5] = '{"div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6] = '{"div_7_m2",     OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  10, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{"div_by_zero",  OP_DIV,   32'd9,        32'd0,        32'd5,  32'd6,  10, 32'd5,        32'd6};
    vecs[8] = '{"divu_by_zero", OP_DIVU,  32'd9,        32'd0,        32'd11, 32'd12, 10, 32'd11,       32'd12};
    vecs[9] = '{"divu_big",     OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0,  32'h0,  10, 32'h0000000F, 32'h0FFFFFFF};

    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("reset_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("reset_hi", h, 32'd0);
    check("reset_lo", l, 32'd0);

    for (int i = 0; i < 10; i++) begin
      mt(OP_MTHI, vecs[i].pre_hi);
      mt(OP_MTLO, vecs[i].pre_lo);
      op = vecs[i].vop; A = vecs[i].a; B = vecs[i].b; start = 1'b1;
      tick();
      idle();
      op = OP_MFLO; #1;
      check({vecs[i].name, "_old_lo_while_busy"}, HILOout, vecs[i].pre_lo);
      op = OP_NONE;
      wait_idle(n);
      check({vecs[i].name, "_busy_cycles"}, n, vecs[i].cycles);
      read_hilo(h, l);
      check({vecs[i].name, "_hi"}, h, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, l, vecs[i].exp_lo);
      $display("vec %0d %s: A=0x%08h B=0x%08h busy=%0d HI=0x%08h LO=0x%08h", i, vecs[i].name, vecs[i].a, vecs[i].b, n, h, l);
    end

    // Non-MF ops drive zero
    op = OP_MULT; #1;
    check("hilo_zero_other_op", HILOout, 32'd0);
    idle();

    // Squash: MTLO and MULT with Req high
    mt(OP_MTHI, 32'hAA);
    mt(OP_MTLO, 32'hBB);
    op = OP_MTLO; A = 32'h1234; Req = 1'b1;
    tick();
    idle();
    op = OP_MULT; A = 32'd3; B = 32'd4; start = 1'b1; Req = 1'b1;
    tick();
    idle();
    check("req_busy", {31'd0, busy}, 32'd0);
    tick(); tick(); tick(); tick(); tick(); tick();
    read_hilo(h, l);
    check("req_hi", h, 32'hAA);
    check("req_lo", l, 32'hBB);
    $display("squash: HI=0x%08h LO=0x%08h", h, l);

    // Start while busy is ignored: the second op must not restart or replace the first
    op = OP_MULT; A = 32'd6; B = 32'd7; start = 1'b1;
    tick();
    op = OP_DIVU; A = 32'd100; B = 32'd3; start = 1'b1;
    tick();
    idle();
    wait_idle(n);
    check("overlap_busy_rest", n, 32'd4);
    read_hilo(h, l);
    check("overlap_hi", h, 32'd0);
    check("overlap_lo", l, 32'd42);
    $display("overlap: HI=0x%08h LO=0x%08h", h, l);

    // Reset mid-operation aborts and discards the result
    op = OP_MULT; A = 32'd3; B = 32'd5; start = 1'b1;
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 8; k++) tick();
    check("rstmid_busy_later", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("rstmid_hi", h, 32'd0);
    check("rstmid_lo", l, 32'd0);
    $display("reset-abort: HI=0x%08h LO=0x%08h", h, l);

`ifdef MDU_MADD_EN
    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'hFFFFFFFF);
    op = OP_MADDU; A = 32'd1; B = 32'd1; start = 1'b1;
    tick();
    idle();
    wait_idle(n);
    check("maddu_busy", n, 32'd5);
    read_hilo(h, l);
    check("maddu_hi", h, 32'd1);
    check("maddu_lo", l, 32'd0);
    op = OP_MADD; A = 32'hFFFFFFFF; B = 32'd1; start = 1'b1;
    tick();
    idle();
    wait_idle(n);
    read_hilo(h, l);
    check("madd_hi", h, 32'd0);
    check("madd_lo", l, 32'hFFFFFFFF);
    $display("madd: HI=0x%08h LO=0x%08h", h, l);
`else
    mt(OP_MTHI, 32'd7);
    mt(OP_MTLO, 32'd8);
    op = OP_MADDU; A = 32'd1; B = 32'd1; start = 1'b1;
    tick();
    idle();
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("madd_off_hi", h, 32'd7);
    check("madd_off_lo", l, 32'd8);
    $display("madd disabled: HI=0x%08h LO=0x%08h", h, l);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
